// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer : drives the PC register and fetches over req/ack into a
//                   valid/ready instruction register.  Rev 1.0
// ============================================================================
module fetch_sequencer #(
    parameter int                ADDR_W    = 16,
    parameter int                INSTR_W   = 16,
    parameter int                PC_INC    = 1,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc,
    output logic               pc_wrt,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ir_valid,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_pc,
    input  logic               ir_ready,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target
);

    localparam logic [1:0]        c_BOOT   = 2'd0;
    localparam logic [1:0]        c_FETCH  = 2'd1;
    localparam logic [1:0]        c_HOLD   = 2'd2;
    localparam logic [ADDR_W-1:0] c_PC_INC = ADDR_W'(PC_INC);

    logic [1:0]         state_q,    state_d;
    logic               ir_valid_q, ir_valid_d;
    logic [INSTR_W-1:0] ir_data_q,  ir_data_d;
    logic [ADDR_W-1:0]  ir_pc_q,    ir_pc_d;

    always_comb begin
        state_d    = state_q;
        ir_valid_d = ir_valid_q;
        ir_data_d  = ir_data_q;
        ir_pc_d    = ir_pc_q;
        pc_wrt     = 1'b1;
        pc_next    = pc;
        imem_req   = 1'b0;
        imem_addr  = pc;

        if (!rst) begin
            // The PC register clears itself while write-enable is low.
            pc_wrt  = 1'b0;
            pc_next = RESET_VEC;
        end else begin
            case (state_q)
                c_BOOT: begin
                    pc_next = RESET_VEC;
                    state_d = c_FETCH;
                end
                c_FETCH: begin
                    imem_req = 1'b1;
                    if (br_taken) begin
                        pc_next    = br_target;
                        ir_valid_d = 1'b0;
                    end else if (imem_ack) begin
                        pc_next    = pc + c_PC_INC;
                        ir_valid_d = 1'b1;
                        ir_data_d  = imem_rdata;
                        ir_pc_d    = pc;
                        state_d    = c_HOLD;
                    end
                end
                c_HOLD: begin
                    if (br_taken) begin
                        pc_next    = br_target;
                        ir_valid_d = 1'b0;
                        state_d    = c_FETCH;
                    end else if (ir_ready) begin
                        ir_valid_d = 1'b0;
                        state_d    = c_FETCH;
                    end
                end
                default: begin
                    pc_next = RESET_VEC;
                    state_d = c_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= c_BOOT;
            ir_valid_q <= 1'b0;
            ir_data_q  <= '0;
            ir_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            ir_valid_q <= ir_valid_d;
            ir_data_q  <= ir_data_d;
            ir_pc_q    <= ir_pc_d;
        end
    end

    assign ir_valid = ir_valid_q;
    assign ir_data  = ir_data_q;
    assign ir_pc    = ir_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer : vector table, directed corner sequences and random
//                      traffic against a behavioural fetch model.  Rev 1.0
// ============================================================================
module tb_fetch_sequencer;

    localparam logic [15:0] c_RESET_VEC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        pc_wrt;
    logic [15:0] pc_next;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        ir_valid;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;
    logic        ir_ready;
    logic        br_taken;
    logic [15:0] br_target;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural view: booting flag plus the instruction register contents.
    bit          m_known = 1'b0;
    bit          m_boot  = 1'b1;
    bit          m_valid = 1'b0;
    logic [15:0] m_data  = '0;
    logic [15:0] m_irpc  = '0;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [15:0] rdata;
        logic        ready;
        logic        br;
        logic [15:0] tgt;
        logic        e_wrt;
        logic        e_req;
        logic [15:0] e_addr;
        logic [15:0] e_next;
        logic        e_valid;
        logic [15:0] e_irpc;
        logic [15:0] e_irdata;
    } vec_t;

    vec_t vt [7];

    fetch_sequencer #(
        .ADDR_W    (16),
        .INSTR_W   (16),
        .PC_INC    (1),
        .RESET_VEC (c_RESET_VEC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_wrt     (pc_wrt),
        .pc_next    (pc_next),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir_valid   (ir_valid),
        .ir_data    (ir_data),
        .ir_pc      (ir_pc),
        .ir_ready   (ir_ready),
        .br_taken   (br_taken),
        .br_target  (br_target)
    );

    always #5 clk = ~clk;

    // External PC register: loads 0 whenever write-enable is low.
    always @(posedge clk) pc <= pc_wrt ? pc_next : 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r, input logic a, input logic [15:0] d,
                          input logic rdy, input logic b, input logic [15:0] t);
        rst        = r;
        imem_ack   = a;
        imem_rdata = d;
        ir_ready   = rdy;
        br_taken   = b;
        br_target  = t;
    endtask

    task automatic model_check();
        logic [15:0] inc;
        inc = 16'(pc + 16'd1);
        chk("model pc_wrt", {31'd0, pc_wrt}, {31'd0, rst});
        if (m_known) begin
            chk("model ir_valid", {31'd0, ir_valid}, {31'd0, m_valid});
            chk("model ir_pc", {16'd0, ir_pc}, {16'd0, m_irpc});
            chk("model ir_data", {16'd0, ir_data}, {16'd0, m_data});
        end
        if (rst) begin
            if (m_boot) begin
                chk("model boot req", {31'd0, imem_req}, 32'd0);
                chk("model boot pc_next", {16'd0, pc_next}, {16'd0, c_RESET_VEC});
            end else if (!m_valid) begin
                chk("model fetch req", {31'd0, imem_req}, 32'd1);
                chk("model fetch addr", {16'd0, imem_addr}, {16'd0, pc});
                chk("model fetch pc_next", {16'd0, pc_next},
                    {16'd0, br_taken ? br_target : (imem_ack ? inc : pc)});
            end else begin
                chk("model hold req", {31'd0, imem_req}, 32'd0);
                chk("model hold pc_next", {16'd0, pc_next},
                    {16'd0, br_taken ? br_target : pc});
            end
        end
    endtask

    task automatic model_update();
        if (!rst) begin
            m_known = 1'b1;
            m_boot  = 1'b1;
            m_valid = 1'b0;
            m_data  = '0;
            m_irpc  = '0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_valid) begin
            if (!br_taken && imem_ack) begin
                m_valid = 1'b1;
                m_data  = imem_rdata;
                m_irpc  = pc;
            end
        end else if (br_taken || ir_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic finish_cycle();
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic r, input logic a, input logic [15:0] d,
                       input logic rdy, input logic b, input logic [15:0] t);
        set_in(r, a, d, rdy, b, t);
        @(negedge clk);
        finish_cycle();
    endtask

    initial begin
        // rst ack rdata ready br tgt | wrt req addr next valid irpc irdata
        vt[0] = '{1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vt[1] = '{1'b1, 1'b1, 16'hA000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0, 16'h0000, 16'h0000};
        vt[2] = '{1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b1, 16'h0000, 16'hA000};
        vt[3] = '{1'b1, 1'b1, 16'hA001, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 16'h0002, 1'b0, 16'h0000, 16'hA000};
        vt[4] = '{1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0002, 1'b1, 16'h0001, 16'hA001};
        vt[5] = '{1'b1, 1'b1, 16'hA002, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 16'h0003, 1'b0, 16'h0001, 16'hA001};
        vt[6] = '{1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0003, 1'b1, 16'h0002, 16'hA002};

        set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b1, 16'h1111, 1'b1, 1'b1, 16'h2222);

        // Single-cycle memory, decode always ready.
        for (int i = 0; i < 7; i++) begin
            set_in(vt[i].rst, vt[i].ack, vt[i].rdata, vt[i].ready, vt[i].br, vt[i].tgt);
            @(negedge clk);
            chk("tbl pc_wrt", {31'd0, pc_wrt}, {31'd0, vt[i].e_wrt});
            chk("tbl imem_req", {31'd0, imem_req}, {31'd0, vt[i].e_req});
            if (vt[i].e_req)
                chk("tbl imem_addr", {16'd0, imem_addr}, {16'd0, vt[i].e_addr});
            chk("tbl pc_next", {16'd0, pc_next}, {16'd0, vt[i].e_next});
            chk("tbl ir_valid", {31'd0, ir_valid}, {31'd0, vt[i].e_valid});
            chk("tbl ir_pc", {16'd0, ir_pc}, {16'd0, vt[i].e_irpc});
            chk("tbl ir_data", {16'd0, ir_data}, {16'd0, vt[i].e_irdata});
            finish_cycle();
        end

        // Reach FETCH at pc=0004, then ack arrives after three wait cycles.
        cyc(1'b1, 1'b1, 16'hC003, 1'b1, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 16'hBAD0, 1'b0, 1'b0, 16'h0000);
            @(negedge clk);
            chk("wait req", {31'd0, imem_req}, 32'd1);
            chk("wait addr", {16'd0, imem_addr}, 32'h0004);
            chk("wait pc_next", {16'd0, pc_next}, 32'h0004);
            chk("wait pc_wrt", {31'd0, pc_wrt}, 32'd1);
            finish_cycle();
        end
        set_in(1'b1, 1'b1, 16'hC004, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        chk("ack addr", {16'd0, imem_addr}, 32'h0004);
        chk("ack pc_next", {16'd0, pc_next}, 32'h0005);
        finish_cycle();

        // Decode stall for four cycles.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b1, 16'hBAD1, 1'b0, 1'b0, 16'h0000);
            @(negedge clk);
            chk("stall valid", {31'd0, ir_valid}, 32'd1);
            chk("stall ir_pc", {16'd0, ir_pc}, 32'h0004);
            chk("stall ir_data", {16'd0, ir_data}, 32'hC004);
            chk("stall req", {31'd0, imem_req}, 32'd0);
            chk("stall pc_next", {16'd0, pc_next}, 32'h0005);
            finish_cycle();
        end
        cyc(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);

        // Fetch resumes at 0005; redirect it to 0010 before any ack.
        set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0010);
        @(negedge clk);
        chk("resume req", {31'd0, imem_req}, 32'd1);
        chk("resume addr", {16'd0, imem_addr}, 32'h0005);
        chk("resume valid", {31'd0, ir_valid}, 32'd0);
        chk("redir pc_next", {16'd0, pc_next}, 32'h0010);
        finish_cycle();

        // Branch in the same cycle as an ack: data is discarded.
        set_in(1'b1, 1'b1, 16'hEEEE, 1'b0, 1'b1, 16'h0100);
        @(negedge clk);
        chk("br+ack addr", {16'd0, imem_addr}, 32'h0010);
        chk("br+ack pc_next", {16'd0, pc_next}, 32'h0100);
        finish_cycle();
        set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        chk("br+ack valid", {31'd0, ir_valid}, 32'd0);
        chk("br+ack ir_data", {16'd0, ir_data}, 32'hC004);
        chk("br+ack new addr", {16'd0, imem_addr}, 32'h0100);
        finish_cycle();
        cyc(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000);

        // Branch in HOLD with ready also high: instruction dropped.
        set_in(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF);
        @(negedge clk);
        chk("hold br pc_next", {16'd0, pc_next}, 32'hFFFF);
        finish_cycle();
        set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        chk("hold br valid", {31'd0, ir_valid}, 32'd0);
        chk("hold br addr", {16'd0, imem_addr}, 32'hFFFF);
        finish_cycle();

        // Wrap-around at FFFF.
        set_in(1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        chk("wrap pc_next", {16'd0, pc_next}, 32'h0000);
        finish_cycle();
        set_in(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        chk("wrap ir_pc", {16'd0, ir_pc}, 32'hFFFF);
        chk("wrap ir_data", {16'd0, ir_data}, 32'h5A5A);
        finish_cycle();
        set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        chk("wrap next addr", {16'd0, imem_addr}, 32'h0000);
        chk("wrap next req", {31'd0, imem_req}, 32'd1);
        finish_cycle();

        // Reset mid-fetch with ack asserted.
        set_in(1'b0, 1'b1, 16'h7777, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        chk("rst pc_wrt", {31'd0, pc_wrt}, 32'd0);
        finish_cycle();
        set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234);
        @(negedge clk);
        chk("rst ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst ir_data", {16'd0, ir_data}, 32'h0000);
        chk("boot pc_next", {16'd0, pc_next}, {16'd0, c_RESET_VEC});
        chk("boot req", {31'd0, imem_req}, 32'd0);
        finish_cycle();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] t;
            t = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + $urandom_range(0, 1)) : 16'($urandom);
            cyc($urandom_range(0, 63) != 0, $urandom_range(0, 1) == 1, 16'($urandom),
                $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
